// File: rtl/seq_detector_param_if.sv
// Configuration, serial-data and status bundle for seq_detector_param.
// master drives config/data; slave is the detector.
interface seq_detector_param_if #(
  parameter int PAT_W = 8,
  parameter int CNT_W = 16
);
  localparam int LEN_W = $clog2(PAT_W) + 1;

  logic             cfg_load;
  logic [PAT_W-1:0] cfg_pattern;
  logic [LEN_W-1:0] cfg_len;
  logic             cfg_overlap;
  logic             in_valid;
  logic             in_bit;
  logic             cnt_clr;
  logic             armed;
  logic             cfg_err;
  logic             detect;
  logic [CNT_W-1:0] match_cnt;

  modport master (
    output cfg_load,
    output cfg_pattern,
    output cfg_len,
    output cfg_overlap,
    output in_valid,
    output in_bit,
    output cnt_clr,
    input  armed,
    input  cfg_err,
    input  detect,
    input  match_cnt
  );

  modport slave (
    input  cfg_load,
    input  cfg_pattern,
    input  cfg_len,
    input  cfg_overlap,
    input  in_valid,
    input  in_bit,
    input  cnt_clr,
    output armed,
    output cfg_err,
    output detect,
    output match_cnt
  );
endinterface

// File: rtl/seq_detector_param.sv
// Runtime-configurable serial pattern detector, Mealy detect strobe.
// SEQ_DETECTOR_COUNT_EN enables the saturating match counter.
module seq_detector_param #(
  parameter int PAT_W = 8,
  parameter int CNT_W = 16
) (
  input logic clk,
  input logic rst,
  seq_detector_param_if.slave bus
);
  localparam int LEN_W = $clog2(PAT_W) + 1;
  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(PAT_W);

  typedef enum logic {
    IDLE,
    ARMED
  } state_t;

  state_t           state_q, state_n;
  logic [PAT_W-1:0] pat_q, pat_n;
  logic [LEN_W-1:0] len_q, len_n;
  logic             ovl_q, ovl_n;
  logic [PAT_W-1:0] hist_q, hist_n;
  logic [LEN_W-1:0] fill_q, fill_n;
  logic             err_q, err_n;

  logic [PAT_W-1:0] mask;
  logic [PAT_W-1:0] win;
  logic [LEN_W:0]   fill_p1;
  logic             fill_ok;
  logic             cfg_ok;
  logic             shift_en;
  logic             match;

  always_comb begin
    mask = '0;
    for (int i = 0; i < PAT_W; i++) begin
      mask[i] = (LEN_W'(i) < len_q);
    end
  end

  assign win     = PAT_W'({hist_q, bus.in_bit});
  assign fill_p1 = {1'b0, fill_q} + (LEN_W+1)'(1);
  assign fill_ok = (fill_p1 >= {1'b0, len_q});
  assign cfg_ok  = (bus.cfg_len != '0) &&
                   (bus.cfg_len <= LEN_MAX);

  // A config load owns the cycle: the data bit is dropped.
  assign shift_en = (state_q == ARMED) &&
                    bus.in_valid &&
                    !bus.cfg_load;

  assign match = shift_en && fill_ok &&
                 (((win ^ pat_q) & mask) == '0);

  always_comb begin
    state_n = state_q;
    pat_n   = pat_q;
    len_n   = len_q;
    ovl_n   = ovl_q;
    hist_n  = hist_q;
    fill_n  = fill_q;
    err_n   = err_q;
    unique case (1'b1)
      bus.cfg_load && cfg_ok: begin
        state_n = ARMED;
        pat_n   = bus.cfg_pattern;
        len_n   = bus.cfg_len;
        ovl_n   = bus.cfg_overlap;
        hist_n  = '0;
        fill_n  = '0;
        err_n   = 1'b0;
      end
      bus.cfg_load && !cfg_ok: begin
        err_n = 1'b1;
      end
      shift_en: begin
        hist_n = win;
        if (match && !ovl_q) begin
          fill_n = '0;
        end else if (fill_q != LEN_MAX) begin
          fill_n = fill_p1[LEN_W-1:0];
        end
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      pat_q   <= '0;
      len_q   <= LEN_W'(1);
      ovl_q   <= 1'b0;
      hist_q  <= '0;
      fill_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_n;
      pat_q   <= pat_n;
      len_q   <= len_n;
      ovl_q   <= ovl_n;
      hist_q  <= hist_n;
      fill_q  <= fill_n;
      err_q   <= err_n;
    end
  end

  assign bus.armed   = (state_q == ARMED);
  assign bus.cfg_err = err_q;
  assign bus.detect  = match;

`ifdef SEQ_DETECTOR_COUNT_EN
  logic [CNT_W-1:0] cnt_q;

  // Clear beats a same-cycle increment.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (bus.cnt_clr) begin
      cnt_q <= '0;
    end else if (match && (cnt_q != '1)) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign bus.match_cnt = cnt_q;
`else
  logic unused_cnt_clr;

  assign unused_cnt_clr = bus.cnt_clr;
  assign bus.match_cnt  = '0;
`endif

endmodule

// File: tb/tb_seq_detector_param.sv
// Directed bench for seq_detector_param (PAT_W=8, CNT_W=2).
// Expected counts follow SEQ_DETECTOR_COUNT_EN.
module tb_seq_detector_param;
  localparam int PAT_W = 8;
  localparam int CNT_W = 2;
`ifdef SEQ_DETECTOR_COUNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  logic clk;
  logic rst;
  int   n_chk;
  int   n_pass;
  int   exp_cnt;

  seq_detector_param_if #(
    .PAT_W(PAT_W),
    .CNT_W(CNT_W)
  ) bus ();

  seq_detector_param #(
    .PAT_W(PAT_W),
    .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      $display("FAIL %s got=%0h exp=%0h",
               tag, got, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic step(input logic v,
                      input logic b,
                      input logic exp_det,
                      input logic clr);
    @(negedge clk);
    bus.cfg_load = 1'b0;
    bus.in_valid = v;
    bus.in_bit   = b;
    bus.cnt_clr  = clr;
    #2;
    chk("detect", 32'(bus.detect), 32'(exp_det));
    if (clr) begin
      exp_cnt = 0;
    end else if (exp_det && exp_cnt < 3) begin
      exp_cnt++;
    end
  endtask

  task automatic run(input logic [15:0] bits,
                     input int n,
                     input logic [15:0] det);
    for (int i = 0; i < n; i++) begin
      step(1'b1, bits[n-1-i], det[n-1-i], 1'b0);
    end
  endtask

  task automatic ld(input logic [7:0] pat,
                    input logic [3:0] len,
                    input logic ovl,
                    input logic v);
    @(negedge clk);
    bus.cfg_load    = 1'b1;
    bus.cfg_pattern = pat;
    bus.cfg_len     = len;
    bus.cfg_overlap = ovl;
    bus.in_valid    = v;
    bus.in_bit      = 1'b1;
    bus.cnt_clr     = 1'b0;
    #2;
    chk("ld_det", 32'(bus.detect), 32'd0);
  endtask

  task automatic status(input logic exp_armed,
                        input logic exp_err);
    @(negedge clk);
    bus.cfg_load = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_bit   = 1'b1;
    bus.cnt_clr  = 1'b0;
    #2;
    chk("armed", 32'(bus.armed), 32'(exp_armed));
    chk("cfg_err", 32'(bus.cfg_err), 32'(exp_err));
    chk("cnt", 32'(bus.match_cnt),
        CNT_ON ? 32'(exp_cnt) : 32'd0);
  endtask

  initial begin
    n_chk           = 0;
    n_pass          = 0;
    exp_cnt         = 0;
    rst             = 1'b0;
    bus.cfg_load    = 1'b0;
    bus.cfg_pattern = '0;
    bus.cfg_len     = '0;
    bus.cfg_overlap = 1'b0;
    bus.in_valid    = 1'b1;
    bus.in_bit      = 1'b1;
    bus.cnt_clr     = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_armed", 32'(bus.armed), 32'd0);
    chk("rst_err", 32'(bus.cfg_err), 32'd0);
    chk("rst_det", 32'(bus.detect), 32'd0);
    chk("rst_cnt", 32'(bus.match_cnt), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    step(1'b1, 1'b1, 1'b0, 1'b0);
    ld(8'h03, 4'd0, 1'b1, 1'b0);
    status(1'b0, 1'b1);

    ld(8'h07, 4'd4, 1'b1, 1'b0);
    status(1'b1, 1'b0);
    run(16'b011110111, 9, 16'b000100001);
    status(1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    status(1'b1, 1'b0);

    ld(8'h03, 4'd2, 1'b1, 1'b1);
    run(16'b1111, 4, 16'b0111);
    status(1'b1, 1'b0);
    ld(8'hA3, 4'd2, 1'b0, 1'b0);
    run(16'b1111, 4, 16'b0101);
    status(1'b1, 1'b0);

    ld(8'h03, 4'd2, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b1);
    status(1'b1, 1'b0);

    ld(8'h00, 4'd0, 1'b0, 1'b0);
    status(1'b1, 1'b1);
    ld(8'h00, 4'd9, 1'b0, 1'b1);
    status(1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    ld(8'h07, 4'd4, 1'b1, 1'b0);
    status(1'b1, 1'b0);

    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    status(1'b1, 1'b0);

    ld(8'h07, 4'd4, 1'b1, 1'b0);
    ld(8'h07, 4'd0, 1'b1, 1'b0);
    status(1'b1, 1'b1);
    run(16'b011, 3, 16'b000);
    @(negedge clk);
    rst          = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_bit   = 1'b1;
    #1;
    chk("mid_armed", 32'(bus.armed), 32'd0);
    chk("mid_err", 32'(bus.cfg_err), 32'd0);
    chk("mid_det", 32'(bus.detect), 32'd0);
    chk("mid_cnt", 32'(bus.match_cnt), 32'd0);
    exp_cnt = 0;
    @(negedge clk);
    rst = 1'b1;
    run(16'b10111, 5, 16'b00000);
    status(1'b0, 1'b0);
    ld(8'h07, 4'd4, 1'b1, 1'b0);
    run(16'b0111, 4, 16'b0001);
    status(1'b1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
